sel_byte_checker: RTL and testbench

Downstream consumer of the byte-select stage: each cycle it samples the 4-bit selector and the byte the select stage produced, recomputes the expected byte from the same 128-bit wide bus, and tags the pair pass/fail. Tagged samples are buffered in a small FIFO with a valid/ready output handshake. Running sample and mismatch counters feed the testbench's end-of-run report.

---
 rtl/sel_byte_checker.sv | 104 ++++++++++
 tb/tb_sel_byte_checker.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/sel_byte_checker.sv
// Recomputes the byte chosen by the select stage from the wide bus and tags each sample pass/fail.
// Tagged samples are queued in a small FIFO with a valid/ready output, alongside saturating sample/mismatch counters.
module sel_byte_checker #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [3:0]       in_sel,
  input  logic [7:0]       in_byte,
  input  logic [127:0]     wide_bus,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_sel,
  output logic [7:0]       out_byte,
  output logic             out_ok,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic             overflow
);

  localparam int PTR_W = $clog2(DEPTH);

  // Byte index the select stage is supposed to pick; first matching group wins.
  function automatic logic [3:0] expected_idx(input logic [3:0] sel);
    case (sel)
      4'b0000, 4'b0001, 4'b1000, 4'b1001, 4'b1100: return 4'd0;
      4'b0010, 4'b0110:                            return 4'd1;
      4'b0100:                                     return 4'd2;
      default:                                     return 4'd15;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [3:0]       exp_idx_p0;
  logic [7:0]       exp_byte_p0;
  logic             ok_p0;
  logic [3:0]       sel_mem  [DEPTH];
  logic [7:0]       byte_mem [DEPTH];
  logic             ok_mem   [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             full;
  logic             push;
  logic             pop;
  logic             drop;

  // Stage p0: combinational compare against the recomputed byte
  always_comb begin
    exp_idx_p0  = expected_idx(in_sel);
    exp_byte_p0 = wide_bus[{exp_idx_p0, 3'b000} +: 8];
    ok_p0       = (in_byte == exp_byte_p0);
  end

  assign out_valid = (count != '0);
  assign full      = (count == (PTR_W+1)'(DEPTH));
  assign pop       = out_valid && out_ready;
  assign push      = in_valid && (!full || pop);
  assign drop      = in_valid && full && !pop;

  // Head fields are masked while empty so the outputs read zero after reset
  assign out_sel  = out_valid ? sel_mem[rd_ptr]  : 4'd0;
  assign out_byte = out_valid ? byte_mem[rd_ptr] : 8'd0;
  assign out_ok   = out_valid ? ok_mem[rd_ptr]   : 1'b0;

  // Stage p1: FIFO storage (data path, not reset)
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      sel_mem[wr_ptr]  <= in_sel;
      byte_mem[wr_ptr] <= in_byte;
      ok_mem[wr_ptr]   <= ok_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      sample_cnt   <= '0;
      mismatch_cnt <= '0;
      overflow     <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr     <= wr_ptr + PTR_W'(1);
        sample_cnt <= sat_inc(sample_cnt);
        if (!ok_p0) mismatch_cnt <= sat_inc(mismatch_cnt);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (drop) overflow <= 1'b1;
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_sel_byte_checker.sv
// Directed bench for sel_byte_checker: a default instance plus a CNT_W=4 instance for counter saturation.
module tb_sel_byte_checker;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [3:0]   in_sel;
  logic [7:0]   in_byte;
  logic [127:0] wide_bus;
  logic         out_ready;

  logic         a_out_valid, b_out_valid;
  logic [3:0]   a_out_sel, b_out_sel;
  logic [7:0]   a_out_byte, b_out_byte;
  logic         a_out_ok, b_out_ok;
  logic [15:0]  a_sample_cnt, a_mismatch_cnt;
  logic [3:0]   b_sample_cnt, b_mismatch_cnt;
  logic         a_overflow, b_overflow;

  int compared = 0;
  int mismatched = 0;

  // Expected byte for sel 0..15 on the golden bus, worked out by hand
  logic [7:0] gold [16] = '{8'ha0, 8'ha0, 8'ha1, 8'hf5, 8'ha2, 8'hf5, 8'ha1, 8'hf5,
                            8'ha0, 8'ha0, 8'hf5, 8'hf5, 8'ha0, 8'hf5, 8'hf5, 8'hf5};

  sel_byte_checker #(.DEPTH(4), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sel(in_sel), .in_byte(in_byte),
    .wide_bus(wide_bus), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_sel(a_out_sel), .out_byte(a_out_byte), .out_ok(a_out_ok),
    .sample_cnt(a_sample_cnt), .mismatch_cnt(a_mismatch_cnt), .overflow(a_overflow)
  );

  sel_byte_checker #(.DEPTH(4), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sel(in_sel), .in_byte(in_byte),
    .wide_bus(wide_bus), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_sel(b_out_sel), .out_byte(b_out_byte), .out_ok(b_out_ok),
    .sample_cnt(b_sample_cnt), .mismatch_cnt(b_mismatch_cnt), .overflow(b_overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_sel = 4'd3; in_byte = 8'h5a; out_ready = 1'b1;
    wide_bus = 128'hf5ef_d5c5_b5a5_9585_a7a6_a5a4_a3a2_a1a0;
    tick();
    tick();
    compared++;
    if ({a_out_valid, a_out_sel, a_out_byte, a_out_ok, a_overflow} !== 15'd0) begin
      mismatched++;
      $display("FAIL reset_outputs: got v=%0b sel=%0h byte=%0h ok=%0b ovf=%0b required all 0",
               a_out_valid, a_out_sel, a_out_byte, a_out_ok, a_overflow);
    end
    compared++;
    if (a_sample_cnt !== 16'd0 || a_mismatch_cnt !== 16'd0) begin
      mismatched++;
      $display("FAIL reset_counters: got %0d/%0d required 0/0", a_sample_cnt, a_mismatch_cnt);
    end
    compared++;
    if (b_out_valid !== 1'b0 || b_sample_cnt !== 4'd0 || b_overflow !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_b: got v=%0b cnt=%0d ovf=%0b required 0", b_out_valid, b_sample_cnt, b_overflow);
    end
    rst = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_golden_sweep();
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_sel = 4'(i); in_byte = gold[i];
      tick();
      compared++;
      if (a_out_valid !== 1'b1 || a_out_sel !== 4'(i) || a_out_byte !== gold[i] || a_out_ok !== 1'b1) begin
        mismatched++;
        $display("FAIL sweep_sel%0d: got v=%0b sel=%0h byte=%0h ok=%0b required v=1 sel=%0h byte=%0h ok=1",
                 i, a_out_valid, a_out_sel, a_out_byte, a_out_ok, i, gold[i]);
      end
    end
    in_valid = 1'b0;
    tick();
    compared++;
    if (a_out_valid !== 1'b0 || a_sample_cnt !== 16'd16 || a_mismatch_cnt !== 16'd0) begin
      mismatched++;
      $display("FAIL sweep_end: got v=%0b cnt=%0d mis=%0d required v=0 cnt=16 mis=0",
               a_out_valid, a_sample_cnt, a_mismatch_cnt);
    end
  endtask

  task automatic test_mismatch();
    out_ready = 1'b1;
    in_valid = 1'b1; in_sel = 4'b0110; in_byte = 8'ha0;
    tick();
    compared++;
    if (a_out_ok !== 1'b0 || a_out_sel !== 4'b0110 || a_mismatch_cnt !== 16'd1 || a_sample_cnt !== 16'd17) begin
      mismatched++;
      $display("FAIL mismatch_sel6: got ok=%0b sel=%0h mis=%0d cnt=%0d required ok=0 sel=6 mis=1 cnt=17",
               a_out_ok, a_out_sel, a_mismatch_cnt, a_sample_cnt);
    end
    in_sel = 4'b1100; in_byte = 8'ha0;
    tick();
    compared++;
    if (a_out_ok !== 1'b1 || a_out_sel !== 4'b1100 || a_mismatch_cnt !== 16'd1 || a_sample_cnt !== 16'd18) begin
      mismatched++;
      $display("FAIL match_sel12: got ok=%0b sel=%0h mis=%0d cnt=%0d required ok=1 sel=c mis=1 cnt=18",
               a_out_ok, a_out_sel, a_mismatch_cnt, a_sample_cnt);
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    for (int j = 0; j < 4; j++) begin
      in_valid = 1'b1; in_sel = 4'(j); in_byte = gold[j];
      tick();
    end
    compared++;
    if (a_overflow !== 1'b0 || a_out_valid !== 1'b1 || a_out_sel !== 4'd0 || a_sample_cnt !== 16'd22) begin
      mismatched++;
      $display("FAIL full_4: got ovf=%0b v=%0b sel=%0h cnt=%0d required ovf=0 v=1 sel=0 cnt=22",
               a_overflow, a_out_valid, a_out_sel, a_sample_cnt);
    end
    in_sel = 4'd4; in_byte = gold[4];
    tick();
    compared++;
    if (a_overflow !== 1'b1 || a_sample_cnt !== 16'd22 || a_mismatch_cnt !== 16'd1) begin
      mismatched++;
      $display("FAIL drop_5: got ovf=%0b cnt=%0d mis=%0d required ovf=1 cnt=22 mis=1",
               a_overflow, a_sample_cnt, a_mismatch_cnt);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      compared++;
      if (a_out_valid !== 1'b1 || a_out_sel !== 4'(j) || a_out_byte !== gold[j]) begin
        mismatched++;
        $display("FAIL drain_%0d: got v=%0b sel=%0h byte=%0h required v=1 sel=%0h byte=%0h",
                 j, a_out_valid, a_out_sel, a_out_byte, j, gold[j]);
      end
      tick();
    end
    compared++;
    if (a_out_valid !== 1'b0 || a_overflow !== 1'b1) begin
      mismatched++;
      $display("FAIL drain_empty: got v=%0b ovf=%0b required v=0 ovf=1", a_out_valid, a_overflow);
    end
  endtask

  task automatic test_back_to_back();
    pulse_reset();
    for (int j = 0; j < 4; j++) begin
      in_valid = 1'b1; in_sel = 4'(j); in_byte = gold[j];
      tick();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1; in_sel = 4'(k + 4); in_byte = gold[k + 4];
      tick();
      compared++;
      if (a_out_valid !== 1'b1 || a_out_sel !== 4'(k + 1) || a_out_byte !== gold[k + 1] || a_overflow !== 1'b0) begin
        mismatched++;
        $display("FAIL b2b_%0d: got v=%0b sel=%0h byte=%0h ovf=%0b required v=1 sel=%0h byte=%0h ovf=0",
                 k, a_out_valid, a_out_sel, a_out_byte, a_overflow, k + 1, gold[k + 1]);
      end
    end
    in_valid = 1'b0;
    for (int j = 8; j < 12; j++) begin
      compared++;
      if (a_out_valid !== 1'b1 || a_out_sel !== 4'(j) || a_out_byte !== gold[j]) begin
        mismatched++;
        $display("FAIL b2b_drain_%0d: got v=%0b sel=%0h byte=%0h required v=1 sel=%0h byte=%0h",
                 j, a_out_valid, a_out_sel, a_out_byte, j, gold[j]);
      end
      tick();
    end
    compared++;
    if (a_out_valid !== 1'b0 || a_sample_cnt !== 16'd12 || a_overflow !== 1'b0) begin
      mismatched++;
      $display("FAIL b2b_end: got v=%0b cnt=%0d ovf=%0b required v=0 cnt=12 ovf=0",
               a_out_valid, a_sample_cnt, a_overflow);
    end
  endtask

  task automatic test_saturation();
    pulse_reset();
    out_ready = 1'b1;
    in_valid = 1'b1; in_sel = 4'd0; in_byte = 8'h00;
    for (int n = 0; n < 20; n++) tick();
    compared++;
    if (b_sample_cnt !== 4'd15 || b_mismatch_cnt !== 4'd15) begin
      mismatched++;
      $display("FAIL sat_b: got %0d/%0d required 15/15", b_sample_cnt, b_mismatch_cnt);
    end
    compared++;
    if (a_sample_cnt !== 16'd20 || a_mismatch_cnt !== 16'd20 || b_out_ok !== 1'b0) begin
      mismatched++;
      $display("FAIL sat_a: got %0d/%0d ok=%0b required 20/20 ok=0", a_sample_cnt, a_mismatch_cnt, b_out_ok);
    end
    rst = 1'b1;
    tick();
    compared++;
    if (b_sample_cnt !== 4'd0 || b_mismatch_cnt !== 4'd0 || b_out_valid !== 1'b0 ||
        a_sample_cnt !== 16'd0 || a_out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL sat_reset: got b=%0d/%0d bv=%0b a=%0d av=%0b required all 0",
               b_sample_cnt, b_mismatch_cnt, b_out_valid, a_sample_cnt, a_out_valid);
    end
    rst = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_golden_sweep();
    test_mismatch();
    test_overflow();
    test_back_to_back();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
